fpnew_rob_issue: RTL and testbench

Core-side initiator and in-order collector for the FPU's valid/ready request/result protocol. It accepts operation requests from the core and issues them to the FPU, stamping each one with a reorder-buffer index as its tag. Results can come back out of order, because the FPU arbitrates across operation groups; this block reorders them by tag and retires them to the core strictly in issue order. It sits between the core's FP dispatch stage and the FPU top.

---
 rtl/fpnew_rob_issue.sv | 150 +++++++++++++++
 tb/tb_fpnew_rob_issue.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_rob_issue.sv
// Core-side issue stage and reorder buffer for the FPU: tags each request with
// its ROB slot and retires the out-of-order results back to the core in issue order.
module fpnew_rob_issue #(
    parameter int unsigned Width    = 64,
    parameter int unsigned ReqWidth = 200,
    parameter int unsigned Depth    = 4,
    parameter int unsigned IdxW     = $clog2(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // core request side
    input  logic [ReqWidth-1:0] core_req_i,
    input  logic                core_valid_i,
    output logic                core_ready_o,
    // FPU request side
    output logic [ReqWidth-1:0] fpu_req_o,
    output logic [IdxW-1:0]     fpu_tag_o,
    output logic                fpu_valid_o,
    input  logic                fpu_ready_i,
    // FPU result side
    input  logic [Width-1:0]    fpu_result_i,
    input  logic [4:0]          fpu_status_i,
    input  logic [IdxW-1:0]     fpu_tag_i,
    input  logic                fpu_out_valid_i,
    output logic                fpu_out_ready_o,
    // core result side
    output logic [Width-1:0]    core_result_o,
    output logic [4:0]          core_status_o,
    output logic                core_rvalid_o,
    input  logic                core_rready_i,
    // control / observability
    input  logic                flush_i,
    output logic                fpu_flush_o,
    output logic                busy_o,
    output logic [IdxW:0]       count_o,
    output logic                err_o
);

    // Handshake rule for every channel: a transfer happens in exactly the cycle
    // where valid and ready are both high; valid never depends on ready.

    localparam logic [IdxW:0]   DepthCnt = (IdxW+1)'(Depth);
    localparam logic [IdxW-1:0] PtrOne   = IdxW'(1);
    localparam logic [IdxW:0]   CntOne   = (IdxW+1)'(1);

    logic [IdxW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [IdxW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [IdxW:0]    count_q, count_d;
    logic [Depth-1:0] alloc_q, alloc_d;
    logic [Depth-1:0] done_q, done_d;
    logic             err_q, err_d;
    logic [Width-1:0] result_q [Depth];
    logic [4:0]       status_q [Depth];

    logic not_full;
    logic alloc_fire;
    logic retire_fire;
    logic res_in;
    logic res_ok;

    assign not_full     = (count_q != DepthCnt);
    assign fpu_valid_o  = core_valid_i & not_full & ~flush_i;
    assign core_ready_o = fpu_ready_i & not_full & ~flush_i;
    assign fpu_req_o    = core_req_i;
    assign fpu_tag_o    = wr_ptr_q;
    assign fpu_flush_o  = flush_i;

    assign alloc_fire  = core_valid_i & core_ready_o;
    assign retire_fire = core_rvalid_o & core_rready_i;

    // A result is only legal for a slot that is allocated and still waiting.
    assign res_in = fpu_out_valid_i & ~flush_i;
    assign res_ok = alloc_q[fpu_tag_i] & ~done_q[fpu_tag_i];

    assign core_rvalid_o   = alloc_q[rd_ptr_q] & done_q[rd_ptr_q];
    assign core_result_o   = result_q[rd_ptr_q];
    assign core_status_o   = status_q[rd_ptr_q];
    assign fpu_out_ready_o = 1'b1;
    assign busy_o          = (count_q != '0);
    assign count_o         = count_q;
    assign err_o           = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        alloc_d  = alloc_q;
        done_d   = done_q;
        err_d    = err_q;

        if (alloc_fire) begin
            alloc_d[wr_ptr_q] = 1'b1;
            done_d[wr_ptr_q]  = 1'b0;
            wr_ptr_d          = wr_ptr_q + PtrOne;
        end
        if (res_in) begin
            if (res_ok) begin
                done_d[fpu_tag_i] = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (retire_fire) begin
            alloc_d[rd_ptr_q] = 1'b0;
            done_d[rd_ptr_q]  = 1'b0;
            rd_ptr_d          = rd_ptr_q + PtrOne;
        end
        case ({alloc_fire, retire_fire})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        // Flush wins over everything except the sticky error flag.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            alloc_d  = '0;
            done_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            alloc_q  <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < int'(Depth); i++) begin
                result_q[i] <= '0;
                status_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            alloc_q  <= alloc_d;
            done_q   <= done_d;
            err_q    <= err_d;
            if (res_in && res_ok) begin
                result_q[fpu_tag_i] <= fpu_result_i;
                status_q[fpu_tag_i] <= fpu_status_i;
            end
        end
    end

endmodule

// File: tb/tb_fpnew_rob_issue.sv
// Directed bench for fpnew_rob_issue: issue, reorder, full/wrap, flush,
// spurious result, backpressure and asynchronous reset.
module tb_fpnew_rob_issue;

  localparam int W  = 64;
  localparam int RW = 200;
  localparam int D  = 4;
  localparam int IW = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [RW-1:0] core_req;
  logic          core_valid;
  logic          core_ready;
  logic [RW-1:0] fpu_req;
  logic [IW-1:0] fpu_tag;
  logic          fpu_valid;
  logic          fpu_ready;
  logic [W-1:0]  fpu_result;
  logic [4:0]    fpu_status;
  logic [IW-1:0] fpu_tag_in;
  logic          fpu_out_valid;
  logic          fpu_out_ready;
  logic [W-1:0]  core_result;
  logic [4:0]    core_status;
  logic          core_rvalid;
  logic          core_rready;
  logic          flush;
  logic          fpu_flush;
  logic          busy;
  logic [IW:0]   count;
  logic          err;

  fpnew_rob_issue #(.Width(W), .ReqWidth(RW), .Depth(D)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_valid_i(core_valid), .core_ready_o(core_ready),
    .fpu_req_o(fpu_req), .fpu_tag_o(fpu_tag), .fpu_valid_o(fpu_valid), .fpu_ready_i(fpu_ready),
    .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_in),
    .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
    .core_result_o(core_result), .core_status_o(core_status), .core_rvalid_o(core_rvalid),
    .core_rready_i(core_rready),
    .flush_i(flush), .fpu_flush_o(fpu_flush), .busy_o(busy), .count_o(count), .err_o(err)
  );

  int total = 0;
  int bad   = 0;

  // expected results queue, filled in issue order, popped on each retire
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic send_result(input logic [IW-1:0] tag, input logic [W-1:0] res, input logic [4:0] st);
    fpu_out_valid = 1'b1;
    fpu_tag_in    = tag;
    fpu_result    = res;
    fpu_status    = st;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic issue(input logic [IW-1:0] exp_tag, input string tag);
    core_valid = 1'b1;
    core_req   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    settle();
    chk({tag, "_tag"}, RW'(fpu_tag), RW'(exp_tag));
    chk({tag, "_ready"}, RW'(core_ready), RW'(1'b1));
    tick();
    core_valid = 1'b0;
  endtask

  // retire the head and check it against the scoreboard
  task automatic retire_check(input string tag);
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk({tag, "_rvalid"}, RW'(core_rvalid), RW'(1'b1));
    chk({tag, "_result"}, RW'(core_result), RW'(exp_v));
    core_rready = 1'b1;
    tick();
    core_rready = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    core_req = '0; core_valid = 1'b0; fpu_ready = 1'b1;
    fpu_result = '0; fpu_status = '0; fpu_tag_in = '0; fpu_out_valid = 1'b0;
    core_rready = 1'b0; flush = 1'b0;
    settle();
    chk("rst_count", RW'(count), '0);
    chk("rst_busy", RW'(busy), '0);
    chk("rst_rvalid", RW'(core_rvalid), '0);
    chk("rst_err", RW'(err), '0);
    chk("rst_outready", RW'(fpu_out_ready), RW'(1'b1));
    chk("rst_result", RW'(core_result), '0);
    chk("rst_tag", RW'(fpu_tag), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // single op: pass-through, zero-latency issue, one-cycle result visibility
    core_valid = 1'b1;
    core_req   = {8{25'h1abcdef}};
    settle();
    chk("s_fpu_valid", RW'(fpu_valid), RW'(1'b1));
    chk("s_fpu_req", fpu_req, {8{25'h1abcdef}});
    chk("s_tag", RW'(fpu_tag), '0);
    tick();
    core_valid = 1'b0;
    chk("s_count1", RW'(count), RW'(1));
    chk("s_busy", RW'(busy), RW'(1'b1));
    tick();
    send_result(2'd0, 64'h3FF0000000000000, 5'h00);
    exp_q.push_back(64'h3FF0000000000000);
    settle();
    chk("s_not_same_cycle", RW'(core_rvalid), '0);
    tick();
    fpu_out_valid = 1'b0;
    retire_check("s_ret");
    chk("s_count0", RW'(count), '0);
    chk("s_rvalid_off", RW'(core_rvalid), '0);

    // backpressure from the FPU blocks issue
    fpu_ready  = 1'b0;
    core_valid = 1'b1;
    settle();
    chk("bp_fpu_ready", RW'(core_ready), '0);
    core_valid = 1'b0;
    fpu_ready  = 1'b1;

    // reorder: issue 0,1,2, return 2,0,1
    do_flush();
    issue(2'd0, "r0");
    issue(2'd1, "r1");
    issue(2'd2, "r2");
    chk("r_count3", RW'(count), RW'(3));
    exp_q.push_back(64'h1111); exp_q.push_back(64'h2222); exp_q.push_back(64'h3333);
    send_result(2'd2, 64'h3333, 5'h01);
    tick();
    chk("r_hold_on2", RW'(core_rvalid), '0);
    send_result(2'd0, 64'h1111, 5'h10);
    settle();
    chk("r_no_same", RW'(core_rvalid), '0);
    tick();
    fpu_out_valid = 1'b0;
    chk("r_status0", RW'(core_status), RW'(5'h10));
    retire_check("r_ret0");
    chk("r_wait1", RW'(core_rvalid), '0);
    chk("r_count2", RW'(count), RW'(2));
    send_result(2'd1, 64'h2222, 5'h04);
    tick();
    fpu_out_valid = 1'b0;
    retire_check("r_ret1");
    chk("r_status2", RW'(core_status), RW'(5'h01));
    retire_check("r_ret2");
    chk("r_count0", RW'(count), '0);

    // full and wrap
    do_flush();
    for (int i = 0; i < D; i++) issue(IW'(i), "f_issue");
    chk("f_count4", RW'(count), RW'(4));
    send_result(2'd0, 64'hAAAA, 5'h00);
    exp_q.push_back(64'hAAAA);
    tick();
    fpu_out_valid = 1'b0;
    core_valid  = 1'b1;
    core_rready = 1'b1;
    settle();
    chk("f_ready_full", RW'(core_ready), '0);
    chk("f_valid_full", RW'(fpu_valid), '0);
    exp_v = exp_q.pop_front();
    chk("f_ret_result", RW'(core_result), RW'(exp_v));
    tick();
    core_rready = 1'b0;
    chk("f_count3", RW'(count), RW'(3));
    chk("f_ready_after", RW'(core_ready), RW'(1'b1));
    chk("f_wrap_tag", RW'(fpu_tag), '0);
    tick();
    core_valid = 1'b0;
    chk("f_count4b", RW'(count), RW'(4));

    // flush with a result arriving in the same cycle
    do_flush();
    issue(2'd0, "x0"); issue(2'd1, "x1"); issue(2'd2, "x2");
    flush      = 1'b1;
    core_valid = 1'b1;
    send_result(2'd1, 64'hDEAD, 5'h1F);
    settle();
    chk("x_fpu_flush", RW'(fpu_flush), RW'(1'b1));
    chk("x_fpu_valid", RW'(fpu_valid), '0);
    tick();
    flush = 1'b0; core_valid = 1'b0; fpu_out_valid = 1'b0;
    chk("x_count", RW'(count), '0);
    chk("x_busy", RW'(busy), '0);
    chk("x_rvalid", RW'(core_rvalid), '0);
    chk("x_err", RW'(err), '0);
    issue(2'd0, "x_after");

    // spurious result for an unallocated tag
    send_result(2'd3, 64'hBAD0, 5'h00);
    tick();
    fpu_out_valid = 1'b0;
    chk("e_err", RW'(err), RW'(1'b1));
    chk("e_rvalid", RW'(core_rvalid), '0);
    chk("e_count", RW'(count), RW'(1));
    send_result(2'd0, 64'h4000000000000000, 5'h02);
    exp_q.push_back(64'h4000000000000000);
    tick();
    fpu_out_valid = 1'b0;
    retire_check("e_ret");
    chk("e_err_sticky", RW'(err), RW'(1'b1));
    chk("e_count0", RW'(count), '0);

    // core backpressure on a completed head
    issue(2'd1, "b1"); issue(2'd2, "b2");
    send_result(2'd1, 64'h5555, 5'h08);
    exp_q.push_back(64'h5555); exp_q.push_back(64'h6666);
    tick();
    send_result(2'd2, 64'h6666, 5'h00);
    settle();
    chk("b_out_ready", RW'(fpu_out_ready), RW'(1'b1));
    chk("b_hold_res", RW'(core_result), RW'(64'h5555));
    tick();
    fpu_out_valid = 1'b0;
    tick();
    chk("b_stable_valid", RW'(core_rvalid), RW'(1'b1));
    chk("b_stable_status", RW'(core_status), RW'(5'h08));
    retire_check("b_ret1");
    retire_check("b_ret2");
    chk("b_count0", RW'(count), '0);

    // asynchronous reset mid-operation
    issue(2'd3, "a3");
    send_result(2'd3, 64'h7777, 5'h00);
    tick();
    fpu_out_valid = 1'b0;
    chk("a_rvalid_pre", RW'(core_rvalid), RW'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    chk("a_rvalid", RW'(core_rvalid), '0);
    chk("a_count", RW'(count), '0);
    chk("a_err", RW'(err), '0);
    chk("a_result", RW'(core_result), '0);
    chk("a_tag", RW'(fpu_tag), '0);
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
